// File: rtl/apb_modport.sv
// apb_modport: APB (AMBA 3 style) completer in front of a DEPTH x 32-bit
// word-addressed memory, with WAIT_STATES extra ACCESS cycles before pready.
//
// Ports:
//   pclk    in   1   clock, all logic on the rising edge
//   prst    in   1   synchronous active-high reset (clears FSM, outputs, memory)
//   psel    in   1   completer select
//   penable in   1   ACCESS-phase strobe
//   pwrite  in   1   1 = write, 0 = read
//   paddr   in  10   word address (bus address bits [11:2])
//   pwdata  in  32   write data, sampled at the completing edge
//   prdata  out 32   registered read data, holds between reads
//   pready  out  1   registered transfer-complete strobe
module apb_modport #(
  parameter int WAIT_STATES = 0,
  parameter int DEPTH       = 1024
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [9:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  // The SETUP phase lasts exactly one bus cycle, so it is decoded from IDLE
  // (psel & !penable) and acted on at its closing edge; the registered state
  // only needs to distinguish "no transfer" from "inside ACCESS".
  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              pready_n;
  logic              latch;
  logic              rd_load;
  logic              mem_we;
  logic [9:0]        rd_addr;
  logic [DATA_W-1:0] rd_word;

  logic [9:0]        addr_p1;
  logic              wr_p1;

  // Memory contents live in an unreset array; a per-word valid bit (reset to
  // 0) makes every word read back as zero after reset without a bulk clear.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;

  always_comb begin
    rd_word = valid[rd_addr] ? mem[rd_addr] : '0;
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pready_n = pready;
    latch    = 1'b0;
    rd_load  = 1'b0;
    mem_we   = 1'b0;
    rd_addr  = addr_p1;
    case (state)
      IDLE: begin
        pready_n = 1'b0;
        if (psel && !penable) begin
          latch   = 1'b1;
          state_n = ACCESS;
          if (WAIT_STATES == 0) begin
            // Zero-wait: data and pready are ready in the first ACCESS cycle,
            // so the read uses the live address rather than the latched one.
            pready_n = 1'b1;
            rd_load  = !pwrite;
            rd_addr  = paddr;
          end else begin
            cnt_n = CNT_W'(WAIT_STATES);
          end
        end
      end
      ACCESS: begin
        if (!(psel && penable)) begin
          state_n  = IDLE;
          pready_n = 1'b0;
          cnt_n    = '0;
        end else if (pready) begin
          mem_we   = wr_p1;
          pready_n = 1'b0;
          state_n  = IDLE;
        end else if (cnt <= CNT_W'(1)) begin
          // Last wait cycle: raise pready at the same edge the counter hits 0.
          cnt_n    = '0;
          pready_n = 1'b1;
          rd_load  = !wr_p1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        pready_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ---- stage p1: SETUP-time capture / ACCESS-time outputs ----
  always_ff @(posedge pclk) begin
    if (prst) begin
      pready <= 1'b0;
      cnt    <= '0;
      prdata <= '0;
      valid  <= '0;
    end else begin
      pready <= pready_n;
      cnt    <= cnt_n;
      if (rd_load) begin
        prdata <= rd_word;
      end
      if (mem_we) begin
        valid[addr_p1] <= 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (latch) begin
      addr_p1 <= paddr;
      wr_p1   <= pwrite;
    end
    if (mem_we && !prst) begin
      mem[addr_p1] <= pwdata;
    end
  end

endmodule

// File: tb/tb_apb_modport.sv
module tb_apb_modport;

  logic        pclk;
  logic        prst_v    [2];
  logic        psel_v    [2];
  logic        penable_v [2];
  logic        pwrite_v  [2];
  logic [9:0]  paddr_v   [2];
  logic [31:0] pwdata_v  [2];
  logic [31:0] prdata_v  [2];
  logic        pready_v  [2];

  // Reference model: plain word array per instance plus the per-cycle
  // expectations the driver derives from the protocol rules.
  logic [31:0] mdl [2][1024];
  logic        exp_pready [2];
  logic [31:0] exp_prdata [2];
  bit          chk_en     [2];
  int          ws         [2];
  logic        hist       [4];

  int n_checks;
  int n_errors;

  apb_modport #(.WAIT_STATES(0), .DEPTH(1024)) dut0 (
    .pclk    (pclk),
    .prst    (prst_v[0]),
    .psel    (psel_v[0]),
    .penable (penable_v[0]),
    .pwrite  (pwrite_v[0]),
    .paddr   (paddr_v[0]),
    .pwdata  (pwdata_v[0]),
    .prdata  (prdata_v[0]),
    .pready  (pready_v[0])
  );

  apb_modport #(.WAIT_STATES(2), .DEPTH(1024)) dut1 (
    .pclk    (pclk),
    .prst    (prst_v[1]),
    .psel    (psel_v[1]),
    .penable (penable_v[1]),
    .pwrite  (pwrite_v[1]),
    .paddr   (paddr_v[1]),
    .pwdata  (pwdata_v[1]),
    .prdata  (prdata_v[1]),
    .pready  (pready_v[1])
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  always @(negedge pclk) begin
    for (int i = 0; i < 2; i++) begin
      if (chk_en[i]) begin
        n_checks++;
        if (pready_v[i] !== exp_pready[i]) begin
          n_errors++;
          $display("FAIL pready dut%0d t=%0t: got %b expected %b", i, $time, pready_v[i], exp_pready[i]);
        end
        n_checks++;
        if (prdata_v[i] !== exp_prdata[i]) begin
          n_errors++;
          $display("FAIL prdata dut%0d t=%0t: got %h expected %h", i, $time, prdata_v[i], exp_prdata[i]);
        end
      end
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic idle(input int i);
    step();
    psel_v[i]     = 1'b0;
    penable_v[i]  = 1'b0;
    exp_pready[i] = 1'b0;
  endtask

  // access=1: reset lands in the first ACCESS cycle of a transfer whose
  // SETUP the caller has already driven.
  task automatic do_reset(input int i, input bit access);
    step();
    prst_v[i] = 1'b1;
    chk_en[i] = 1'b0;
    if (access) begin
      penable_v[i] = 1'b1;
    end else begin
      psel_v[i]    = 1'b0;
      penable_v[i] = 1'b0;
    end
    step();
    psel_v[i]    = 1'b0;
    penable_v[i] = 1'b0;
    step();
    prst_v[i]     = 1'b0;
    chk_en[i]     = 1'b1;
    exp_pready[i] = 1'b0;
    exp_prdata[i] = 32'h0;
    for (int a = 0; a < 1024; a++) mdl[i][a] = 32'h0;
  endtask

  // One transfer: SETUP then ACCESS positions 0..ws. pready must be high in
  // position ws exactly, where read data also appears. abort_at >= 0 drops
  // psel in that ACCESS position, so nothing is written.
  task automatic xfer(input int i, input bit wr, input logic [9:0] a,
                      input logic [31:0] d, input int abort_at);
    step();
    psel_v[i]     = 1'b1;
    penable_v[i]  = 1'b0;
    pwrite_v[i]   = wr;
    paddr_v[i]    = a;
    pwdata_v[i]   = d;
    exp_pready[i] = 1'b0;
    for (int k = 0; k <= ws[i]; k++) begin
      step();
      if (k == abort_at) begin
        psel_v[i]    = 1'b0;
        penable_v[i] = 1'b0;
      end else begin
        penable_v[i] = 1'b1;
      end
      exp_pready[i] = (k == ws[i]);
      if (k == ws[i] && !wr) exp_prdata[i] = mdl[i][a];
      @(negedge pclk);
      hist[k] = pready_v[i];
      if (k == abort_at) return;
    end
    if (wr) mdl[i][a] = d;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    ws[0] = 0;
    ws[1] = 2;
    for (int i = 0; i < 2; i++) begin
      prst_v[i]     = 1'b1;
      psel_v[i]     = 1'b0;
      penable_v[i]  = 1'b0;
      pwrite_v[i]   = 1'b0;
      paddr_v[i]    = '0;
      pwdata_v[i]   = '0;
      chk_en[i]     = 1'b0;
      exp_pready[i] = 1'b0;
      exp_prdata[i] = '0;
    end

    // ---------------- zero-wait instance ----------------
    do_reset(0, 1'b0);
    @(negedge pclk);
    lit("reset pready", {31'h0, pready_v[0]}, 32'h0);
    lit("reset prdata", prdata_v[0], 32'h0);
    xfer(0, 1'b0, 10'h005, 32'h0, -1);
    lit("read 0x005 after reset", prdata_v[0], 32'h0);
    idle(0);

    xfer(0, 1'b1, 10'h010, 32'hDEADBEEF, -1);
    lit("zero-wait write pready", {31'h0, hist[0]}, 32'h1);
    idle(0);
    xfer(0, 1'b0, 10'h010, 32'h0, -1);
    lit("zero-wait read pready", {31'h0, hist[0]}, 32'h1);
    lit("read 0x010", prdata_v[0], 32'hDEADBEEF);
    idle(0);

    xfer(0, 1'b1, 10'h000, 32'h11111111, -1);
    xfer(0, 1'b1, 10'h3FF, 32'h22222222, -1);
    xfer(0, 1'b0, 10'h000, 32'h0, -1);
    lit("read 0x000", prdata_v[0], 32'h11111111);
    xfer(0, 1'b0, 10'h3FF, 32'h0, -1);
    lit("read 0x3FF", prdata_v[0], 32'h22222222);

    xfer(0, 1'b1, 10'h001, 32'hA5A5A5A5, -1);
    xfer(0, 1'b0, 10'h001, 32'h0, -1);
    lit("back-to-back read 0x001", prdata_v[0], 32'hA5A5A5A5);
    idle(0);

    xfer(0, 1'b1, 10'h030, 32'hCAFEF00D, -1);
    idle(0);
    xfer(0, 1'b1, 10'h030, 32'h12345678, 0);
    idle(0);
    xfer(0, 1'b0, 10'h030, 32'h0, -1);
    lit("read 0x030 after abort", prdata_v[0], 32'hCAFEF00D);
    idle(0);

    // penable without SETUP from IDLE must be ignored
    step();
    psel_v[0] = 1'b1; penable_v[0] = 1'b1; pwrite_v[0] = 1'b1;
    paddr_v[0] = 10'h030; pwdata_v[0] = 32'h0BADF00D; exp_pready[0] = 1'b0;
    step();
    exp_pready[0] = 1'b0;
    @(negedge pclk);
    lit("violation pready", {31'h0, pready_v[0]}, 32'h0);
    step();
    psel_v[0] = 1'b0; exp_pready[0] = 1'b0;
    idle(0);
    xfer(0, 1'b0, 10'h030, 32'h0, -1);
    lit("read 0x030 after violation", prdata_v[0], 32'hCAFEF00D);
    idle(0);

    // reset in the middle of a write
    xfer(0, 1'b1, 10'h040, 32'h55AA55AA, -1);
    step();
    psel_v[0] = 1'b1; penable_v[0] = 1'b0; pwrite_v[0] = 1'b1;
    paddr_v[0] = 10'h050; pwdata_v[0] = 32'h99999999; exp_pready[0] = 1'b0;
    do_reset(0, 1'b1);
    @(negedge pclk);
    lit("mid-reset pready", {31'h0, pready_v[0]}, 32'h0);
    lit("mid-reset prdata", prdata_v[0], 32'h0);
    xfer(0, 1'b0, 10'h040, 32'h0, -1);
    lit("read 0x040 after reset", prdata_v[0], 32'h0);
    xfer(0, 1'b0, 10'h050, 32'h0, -1);
    lit("read 0x050 after reset", prdata_v[0], 32'h0);
    idle(0);

    // ---------------- two-wait-state instance ----------------
    do_reset(1, 1'b0);
    xfer(1, 1'b1, 10'h020, 32'hBAD0BAD0, 1);
    idle(1);
    xfer(1, 1'b0, 10'h020, 32'h0, -1);
    lit("ws2 read after early abort", prdata_v[1], 32'h0);
    idle(1);
    xfer(1, 1'b1, 10'h020, 32'h77778888, -1);
    lit("ws2 pready access0", {31'h0, hist[0]}, 32'h0);
    lit("ws2 pready access1", {31'h0, hist[1]}, 32'h0);
    lit("ws2 pready access2", {31'h0, hist[2]}, 32'h1);
    idle(1);
    xfer(1, 1'b0, 10'h020, 32'h0, -1);
    lit("ws2 read pready access2", {31'h0, hist[2]}, 32'h1);
    lit("ws2 read 0x020", prdata_v[1], 32'h77778888);
    idle(1);

    // ---------------- randomized traffic on both instances ----------------
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 150; n++) begin
        logic [9:0] a;
        bit         wr;
        int         ab;
        a  = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 7))
                                         : 10'($urandom_range(1016, 1023));
        wr = ($urandom_range(0, 1) == 1);
        ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, ws[i])) : -1;
        xfer(i, wr, a, $urandom, ab);
        if ($urandom_range(0, 2) == 0) idle(i);
      end
      idle(i);
      idle(i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_modport.md
Name: apb_modport

Overview:
- APB (AMBA 3 style) completer wrapping a 1024 x 32-bit word-addressed memory.
- Sits behind the APB interface bundle and is driven by a bus requester: the testbench driver or an upstream bridge.
- Implements the SETUP/ACCESS handshake with a configurable number of wait states.
- Supports single-word reads and writes; no byte strobes, no error response.

Parameters:
- WAIT_STATES, 0, extra ACCESS cycles before pready asserts (0 = zero-wait, pready high in first ACCESS cycle).
- DEPTH, 1024, number of 32-bit words; must equal 2^10 to match paddr[11:2].

Ports:
- pclk  input  1  clock, all logic on rising edge.
- prst  input  1  reset, synchronous, active-high.
- psel  input  1  completer select.
- penable  input  1  ACCESS-phase strobe.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  10 (bits [11:2])  word address.
- pwdata  input  32  write data.
- prdata  output  32  read data, registered.
- pready  output  1  transfer-complete strobe, registered.

Behaviour:
- Reset (prst=1 at a rising edge):
  - FSM goes to IDLE; pready=0; prdata=0; wait counter=0.
  - All memory words are cleared to 0; reset takes priority over any bus activity.
- FSM state IDLE:
  - psel=1, penable=0 -> SETUP.
  - penable=1 without a prior SETUP is a protocol violation: ignored, no access, pready stays 0.
- FSM state SETUP (first cycle sampled with psel=1, penable=0):
  - At the closing edge, latch paddr and pwrite and go to ACCESS.
  - If WAIT_STATES=0, set pready<=1 at that edge.
  - If WAIT_STATES=0 and it is a read, also load prdata<=mem[paddr].
  - Otherwise load the wait counter with WAIT_STATES.
- FSM state ACCESS (psel=1, penable=1):
  - While the counter is nonzero, decrement it and keep pready=0.
  - When the counter reaches 0, set pready<=1 and, for a read, load prdata at the same edge.
  - Transfer completes at the rising edge where psel & penable & pready are all 1.
  - On a write completion, mem[latched addr] <= pwdata (pwdata sampled at that edge).
  - After completion: pready<=0; next state is SETUP if psel=1 and penable=0, else IDLE (back-to-back transfers allowed).
- Zero-wait guarantee (WAIT_STATES=0): pready is 1 in every cycle where psel & penable are 1 following a valid SETUP.
  - A write therefore takes exactly 2 cycles (SETUP + ACCESS).
  - A read presents data in the first ACCESS cycle.
- Abort: psel deasserted in SETUP or ACCESS -> return to IDLE with no memory update and pready<=0.
- Address stability: paddr, pwrite and pwdata must be stable from SETUP through completion.
  - The latched address/direction from SETUP is used for the access.
- prdata: holds its last read value between reads; writes never modify prdata.
- Read-after-write to the same address returns the newly written data (no bypass needed, write commits before the next SETUP).
- No byte lanes; every write is a full 32-bit word.

Test Plan:
- Reset: assert prst for 2 cycles with the bus idle -> pready=0, prdata=0; then a read at paddr=0x005 returns 0x00000000.
- Zero-wait write/read: write 0xDEADBEEF to paddr=0x010 (SETUP then ACCESS), then read paddr=0x010.
  - pready=1 in the ACCESS cycle of both transfers; each transfer takes exactly 2 cycles.
  - Read returns prdata=0xDEADBEEF.
- Address boundaries: write 0x11111111 to paddr=0x000 and 0x22222222 to paddr=0x3FF, then read both.
  - Reads return the matching values; no aliasing between the two locations.
- Back-to-back: write A5A5A5A5@0x001, then immediately read @0x001, with no IDLE cycle between them -> read returns 0xA5A5A5A5.
- Wait states (WAIT_STATES=2): write @0x020 holding psel & penable -> pready stays 0 for 2 ACCESS cycles, rises in the 3rd; memory updates only then.
- Abort/violation:
  - Drop psel during ACCESS of a write of 0x12345678 to 0x030 -> a subsequent read of 0x030 returns its previous value.
  - penable=1 from IDLE without SETUP -> pready stays 0.
  - Mid-transfer prst -> FSM in IDLE, pready=0, memory cleared.
